cpm_fifo_drain: RTL

CPM_FIFO_DRAIN -- requirements
Module: cpm_fifo_drain

---
 rtl/cpm_fifo_drain_pkg.sv | 25 ++
 rtl/cpm_word_serializer.sv | 43 ++++
 rtl/cpm_fifo_drain.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpm_fifo_drain_pkg.sv
// Shared CPM definitions: drain FSM state encoding, default widths and the
// word-to-beat ratio with its helper functions.
package cpm_fifo_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } cpm_state_e;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int RATIO          = DEF_DATA_WIDTH / DEF_OUT_WIDTH;

    function automatic int cpm_ratio(input int data_width, input int out_width);
        return data_width / out_width;
    endfunction

    // A one-beat word still needs a 1-bit counter to keep the port legal.
    function automatic int beat_cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/cpm_word_serializer.sv
// Splits one FIFO word into OUT_WIDTH beats, lowest slice first, with a
// wrapping beat counter that flags the final beat of the word.
module cpm_word_serializer
    import cpm_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int BEATS      = RATIO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  advance,
    output logic [OUT_WIDTH-1:0]  beat_data,
    output logic                  last_beat
);

    localparam int BW = beat_cnt_width(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         beat_cnt;

    // NOTE: the shift register is ordinary datapath flops, so it shares the
    // async reset; no memory array here needs special reset handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            shreg    <= word;
            beat_cnt <= '0;
        end else if (advance) begin
            shreg    <= shreg >> OUT_WIDTH;
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        end
    end

    assign beat_data = shreg[OUT_WIDTH-1:0];
    assign last_beat = (beat_cnt == LAST_BEAT);

endmodule

// File: rtl/cpm_fifo_drain.sv
// Burst drain engine: pops burst_len words from a FIFO and streams each one
// downstream as RATIO narrower beats, reloading back-to-back when possible.
module cpm_fifo_drain
    import cpm_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic [7:0]            burst_len,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int WORD_RATIO = cpm_ratio(DATA_WIDTH, OUT_WIDTH);

    cpm_state_e            state, next_state;
    logic [7:0]            word_cnt;
    logic                  ser_load, ser_advance, last_beat;
    logic                  cnt_load, cnt_dec;
    logic                  final_word;
    logic [OUT_WIDTH-1:0]  beat_data;

    cpm_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .BEATS      (WORD_RATIO)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .word      (fifo_data),
        .advance   (ser_advance),
        .beat_data (beat_data),
        .last_beat (last_beat)
    );

    assign final_word = (word_cnt <= 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
        end else begin
            state <= next_state;
            if (clear)
                word_cnt <= '0;
            else if (cnt_load)
                word_cnt <= burst_len;
            else if (cnt_dec && word_cnt != 8'd0)
                word_cnt <= word_cnt - 8'd1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        fifo_pop    = 1'b0;
        ser_load    = 1'b0;
        ser_advance = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        done        = 1'b0;
        busy        = (state != ST_IDLE);

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    cnt_load   = 1'b1;
                    next_state = (burst_len == 8'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    ser_load   = 1'b1;
                    next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = beat_data;
                out_last  = last_beat && final_word;
                if (out_ready) begin
                    ser_advance = 1'b1;
                    if (last_beat) begin
                        cnt_dec = 1'b1;
                        if (final_word) begin
                            next_state = ST_DONE;
                        end else if (!fifo_empty) begin
                            // Zero-bubble reload of the next word.
                            fifo_pop = 1'b1;
                            ser_load = 1'b1;
                        end else begin
                            next_state = ST_FETCH;
                        end
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (clear) begin
            next_state  = ST_IDLE;
            fifo_pop    = 1'b0;
            ser_load    = 1'b0;
            ser_advance = 1'b0;
            cnt_load    = 1'b0;
            cnt_dec     = 1'b0;
            done        = 1'b0;
        end
    end

endmodule
